// File: rtl/mips_pkg.sv
// mips_pkg: memory-control field positions, access sizes, writeback FSM states and byte-enable helpers.
package mips_pkg;
  localparam int MC_LOAD  = 0;
  localparam int MC_STORE = 1;
  localparam int MC_SIZE  = 2;
  localparam int MC_UNS   = 4;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} mem_size_e;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} wb_state_e;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] off);
    return size == SZ_BYTE ? BE_BYTE0 << off : size == SZ_HALF ? (off[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
  endfunction
  // Encoding 2'b11 is treated as a word so it can never slip through unaligned.
  function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
    return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? off[0] : |off;
  endfunction
endpackage

// File: rtl/writeback_module_if.sv
// writeback_module_if: data-memory req/ready port between the writeback stage and memory.
interface writeback_module_if #(parameter int W = 32);
  logic         mem_req_out;
  logic         mem_we_out;
  logic [W-1:0] mem_addr_out;
  logic [W-1:0] mem_wdata_out;
  logic [3:0]   mem_be_out;
  logic         mem_ready_in;
  logic [W-1:0] mem_rdata_in;
  modport master (output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out, input mem_ready_in, mem_rdata_in);
  modport slave (input mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_be_out, output mem_ready_in, mem_rdata_in);
endinterface

// File: rtl/load_aligner.sv
// load_aligner: selects the addressed byte/half lane of a little-endian read word and extends it.
module load_aligner
  import mips_pkg::*;
#(parameter int W = 32) (
  input  logic [W-1:0] rdata_i,
  input  logic [1:0]   off_i,
  input  mem_size_e    size_i,
  input  logic         uns_i,
  output logic [W-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata_i[{off_i, 3'b000} +: 8];
  assign h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign data_o = size_i == SZ_BYTE ? {{(W-8){~uns_i & b[7]}}, b}
                : size_i == SZ_HALF ? {{(W-16){~uns_i & h[15]}}, h} : rdata_i;
endmodule

// File: rtl/writeback_module.sv
// writeback_module: MEM/WB stage driving the register-file write port over a req/ready data memory.
// Define WB_TIMEOUT_EN to abort an access after TIMEOUT cycles without mem_ready_in.
module writeback_module
  import mips_pkg::*;
#(parameter int W = 32, parameter int TIMEOUT = 15) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [4:0]        mem_ctl_in,
  input  logic              reg_write_en_in,
  input  logic [4:0]        reg_write_dest_in,
  input  logic [W-1:0]      alu_result_in,
  input  logic [W-1:0]      store_data_in,
  input  logic [W-1:0]      pc_seq_in,
  output logic              stall_out,
  writeback_module_if.master mem,
  output logic              reg_write_en_out,
  output logic [4:0]        reg_write_dest_out,
  output logic [W-1:0]      reg_write_data_out,
  output logic [W-1:0]      pc_seq_2_out,
  output logic              mem_error_out
);
  wb_state_e    state_q, state_d;
  logic [W-1:0] addr_q, addr_d, pc_q, pc_d, wdata_q, wdata_d;
  mem_size_e    size_q, size_d;
  logic         uns_q, uns_d, we_q, we_d, wen_q, wen_d, err_q, err_d;
  logic [4:0]   dest_q, dest_d, wb_dest_q, wb_dest_d;
  logic [3:0]   be_q, be_d;
  logic         wb_en_q, wb_en_d;
  logic [W-1:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d, load_data;
  mem_size_e    in_size;
  logic         is_mem;
  assign in_size = mem_size_e'(mem_ctl_in[MC_SIZE +: 2]);
  assign is_mem  = mem_ctl_in[MC_LOAD] | mem_ctl_in[MC_STORE];
  load_aligner #(.W(W)) u_align (
    .rdata_i(mem.mem_rdata_in), .off_i(addr_q[1:0]), .size_i(size_q), .uns_i(uns_q), .data_o(load_data)
  );
`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == ACCESS && !mem.mem_ready_in) ? cnt_q + CW'(1) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT > 0;
`endif
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    we_d      = we_q;
    wen_d     = wen_q;
    dest_d    = dest_q;
    pc_d      = pc_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    wb_en_d   = 1'b0;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    wb_pc_d   = wb_pc_q;
    if (state_q == IDLE) begin
      if (valid_in && !is_mem) begin
        wb_en_d   = reg_write_en_in && reg_write_dest_in != 5'd0;
        wb_dest_d = reg_write_dest_in;
        wb_data_d = alu_result_in;
        wb_pc_d   = pc_seq_in;
      end else if (valid_in && misaligned(in_size, alu_result_in[1:0])) begin
        err_d = 1'b1;
      end else if (valid_in) begin
        state_d = ACCESS;
        addr_d  = alu_result_in;
        size_d  = in_size;
        uns_d   = mem_ctl_in[MC_UNS];
        we_d    = mem_ctl_in[MC_STORE];
        wen_d   = !mem_ctl_in[MC_STORE] && reg_write_en_in && reg_write_dest_in != 5'd0;
        dest_d  = reg_write_dest_in;
        pc_d    = pc_seq_in;
        be_d    = byte_en(in_size, alu_result_in[1:0]);
        wdata_d = in_size == SZ_BYTE ? {4{store_data_in[7:0]}}
                : in_size == SZ_HALF ? {2{store_data_in[15:0]}} : store_data_in;
      end
    end else if (mem.mem_ready_in) begin
      state_d = IDLE;
      if (!we_q) begin
        wb_en_d   = wen_q;
        wb_dest_d = dest_q;
        wb_data_d = load_data;
        wb_pc_d   = pc_q;
      end
    end
`ifdef WB_TIMEOUT_EN
    else if (cnt_q == CW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      wen_q     <= 1'b0;
      dest_q    <= '0;
      pc_q      <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      wb_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      we_q      <= we_d;
      wen_q     <= wen_d;
      dest_q    <= dest_d;
      pc_q      <= pc_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      wb_en_q   <= wb_en_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
      wb_pc_q   <= wb_pc_d;
    end
  end
  // Memory-side outputs come only from registers so valid_in never reaches them combinationally.
  assign stall_out          = state_q == ACCESS;
  assign mem.mem_req_out    = state_q == ACCESS;
  assign mem.mem_we_out     = state_q == ACCESS && we_q;
  assign mem.mem_addr_out   = state_q == ACCESS ? {addr_q[W-1:2], 2'b00} : '0;
  assign mem.mem_wdata_out  = state_q == ACCESS && we_q ? wdata_q : '0;
  assign mem.mem_be_out     = state_q == ACCESS ? be_q : '0;
  assign reg_write_en_out   = wb_en_q;
  assign reg_write_dest_out = wb_dest_q;
  assign reg_write_data_out = wb_data_q;
  assign pc_seq_2_out       = wb_pc_q;
  assign mem_error_out      = err_q;
endmodule

// File: tb/tb_writeback_module.sv
// tb_writeback_module: directed table and sequence checks for the writeback stage.
module tb_writeback_module;
  logic        clk = 0, reset = 1, valid_in = 0, reg_write_en_in = 0;
  logic [4:0]  mem_ctl_in = '0, reg_write_dest_in = '0;
  logic [31:0] alu_result_in = '0, store_data_in = '0, pc_seq_in = '0;
  logic        stall_out, reg_write_en_out, mem_error_out;
  logic [4:0]  reg_write_dest_out;
  logic [31:0] reg_write_data_out, pc_seq_2_out;
  int          checks = 0, errors = 0;
  writeback_module_if #(.W(32)) mem_if ();
  writeback_module #(.W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_ctl_in(mem_ctl_in),
    .reg_write_en_in(reg_write_en_in), .reg_write_dest_in(reg_write_dest_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .pc_seq_in(pc_seq_in),
    .stall_out(stall_out), .mem(mem_if), .reg_write_en_out(reg_write_en_out),
    .reg_write_dest_out(reg_write_dest_out), .reg_write_data_out(reg_write_data_out),
    .pc_seq_2_out(pc_seq_2_out), .mem_error_out(mem_error_out)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mem_op(input string nm, input logic [4:0] ctl, input logic [31:0] addr, sdata,
                        input logic [4:0] dest, input logic [31:0] rdata, input int waitc,
                        input logic [3:0] be, input logic [31:0] wd, input logic en, input logic [31:0] data);
    logic [31:0] pc;
    pc = 32'h8000_0000 | addr;
    valid_in = 1; mem_ctl_in = ctl; alu_result_in = addr; store_data_in = sdata;
    reg_write_en_in = ctl[0]; reg_write_dest_in = dest; pc_seq_in = pc;
    step();
    valid_in = 0; alu_result_in = 32'h0BAD_0BAD; store_data_in = 32'h0BAD_0BAD;
    chk({nm, " stall"}, 32'(stall_out), 1);
    chk({nm, " req"}, 32'(mem_if.mem_req_out), 1);
    chk({nm, " we"}, 32'(mem_if.mem_we_out), 32'(ctl[1]));
    chk({nm, " be"}, 32'(mem_if.mem_be_out), 32'(be));
    chk({nm, " addr"}, mem_if.mem_addr_out, addr & ~32'h3);
    if (ctl[1]) chk({nm, " wdata"}, mem_if.mem_wdata_out, wd);
    for (int i = 1; i < waitc; i++) begin
      step();
      chk({nm, " stall wait"}, 32'(stall_out), 1);
      chk({nm, " addr wait"}, mem_if.mem_addr_out, addr & ~32'h3);
    end
    mem_if.mem_ready_in = 1; mem_if.mem_rdata_in = rdata;
    step();
    mem_if.mem_ready_in = 0; mem_if.mem_rdata_in = '0;
    chk({nm, " wen"}, 32'(reg_write_en_out), 32'(en));
    if (en) begin
      chk({nm, " data"}, reg_write_data_out, data);
      chk({nm, " dest"}, 32'(reg_write_dest_out), 32'(dest));
      chk({nm, " pc"}, pc_seq_2_out, pc);
    end
    chk({nm, " stall done"}, 32'(stall_out), 0);
    chk({nm, " req done"}, 32'(mem_if.mem_req_out), 0);
    step();
    chk({nm, " wen pulse"}, 32'(reg_write_en_out), 0);
  endtask
  typedef struct {
    logic v; logic wen; logic [4:0] dest; logic [31:0] alu; logic [31:0] pc; logic exp_en;
  } alu_vec_t;
  alu_vec_t tv[6];
  int n;
  initial begin
    mem_if.mem_ready_in = 0; mem_if.mem_rdata_in = '0;
    tv[0] = '{1, 1, 5'd8,  32'h0000_1234, 32'h0000_0400, 1};
    tv[1] = '{1, 1, 5'd0,  32'h0000_DEAD, 32'h0000_0404, 0};
    tv[2] = '{1, 0, 5'd5,  32'h0000_5555, 32'h0000_0408, 0};
    tv[3] = '{0, 1, 5'd9,  32'h1111_1111, 32'h0000_040C, 0};
    tv[4] = '{1, 1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0410, 1};
    tv[5] = '{1, 1, 5'd1,  32'h8000_0001, 32'h0000_0414, 1};
    #12;
    chk("rst wen", 32'(reg_write_en_out), 0);
    chk("rst dest", 32'(reg_write_dest_out), 0);
    chk("rst data", reg_write_data_out, 0);
    chk("rst pc", pc_seq_2_out, 0);
    chk("rst stall", 32'(stall_out), 0);
    chk("rst req", 32'(mem_if.mem_req_out), 0);
    chk("rst we", 32'(mem_if.mem_we_out), 0);
    chk("rst addr", mem_if.mem_addr_out, 0);
    chk("rst wdata", mem_if.mem_wdata_out, 0);
    chk("rst be", 32'(mem_if.mem_be_out), 0);
    chk("rst err", 32'(mem_error_out), 0);
    @(negedge clk); reset = 0;
    step();
    foreach (tv[i]) begin
      valid_in = tv[i].v; mem_ctl_in = '0; reg_write_en_in = tv[i].wen;
      reg_write_dest_in = tv[i].dest; alu_result_in = tv[i].alu; pc_seq_in = tv[i].pc;
      step();
      valid_in = 0;
      chk($sformatf("alu%0d wen", i), 32'(reg_write_en_out), 32'(tv[i].exp_en));
      chk($sformatf("alu%0d req", i), 32'(mem_if.mem_req_out), 0);
      chk($sformatf("alu%0d stall", i), 32'(stall_out), 0);
      if (tv[i].v) begin
        chk($sformatf("alu%0d dest", i), 32'(reg_write_dest_out), 32'(tv[i].dest));
        chk($sformatf("alu%0d data", i), reg_write_data_out, tv[i].alu);
        chk($sformatf("alu%0d pc", i), pc_seq_2_out, tv[i].pc);
      end
    end
    step();
    chk("alu pulse", 32'(reg_write_en_out), 0);
    mem_op("lb",   5'b00001, 32'h103, 0, 5'd4, 32'h80FF_FFFF, 3, 4'b1000, 0, 1, 32'hFFFF_FF80);
    mem_op("lbu",  5'b10001, 32'h101, 0, 5'd6, 32'h0000_9900, 1, 4'b0010, 0, 1, 32'h0000_0099);
    mem_op("lhu",  5'b10101, 32'h102, 0, 5'd7, 32'h8001_1234, 1, 4'b1100, 0, 1, 32'h0000_8001);
    mem_op("lh",   5'b00101, 32'h100, 0, 5'd3, 32'h0000_8001, 2, 4'b0011, 0, 1, 32'hFFFF_8001);
    mem_op("lw",   5'b01001, 32'h204, 0, 5'd2, 32'hCAFE_BABE, 2, 4'b1111, 0, 1, 32'hCAFE_BABE);
    mem_op("sh",   5'b00110, 32'h102, 32'h0000_ABCD, 5'd0, 0, 1, 4'b1100, 32'hABCD_ABCD, 0, 0);
    mem_op("sb",   5'b00010, 32'h101, 32'h1234_5677, 5'd0, 0, 2, 4'b0010, 32'h7777_7777, 0, 0);
    mem_op("lb r0", 5'b00001, 32'h100, 0, 5'd0, 32'h0000_0055, 1, 4'b0001, 0, 0, 0);
    mem_if.mem_ready_in = 1; mem_if.mem_rdata_in = 32'h1234_5678;
    step();
    mem_if.mem_ready_in = 0;
    chk("idle ready wen", 32'(reg_write_en_out), 0);
    chk("idle ready stall", 32'(stall_out), 0);
    valid_in = 1; mem_ctl_in = 5'b01001; alu_result_in = 32'h200; reg_write_en_in = 1; reg_write_dest_in = 5'd9;
    step();
    valid_in = 0;
    n = 0;
`ifdef WB_TIMEOUT_EN
    while (mem_if.mem_req_out && n < 40) begin n++; step(); end
    chk("timeout cycles", n, 15);
    chk("timeout err", 32'(mem_error_out), 1);
    chk("timeout stall", 32'(stall_out), 0);
    chk("timeout wen", 32'(reg_write_en_out), 0);
`else
    for (int i = 0; i < 20; i++) step();
    chk("wait req held", 32'(mem_if.mem_req_out), 1);
    chk("wait err", 32'(mem_error_out), 0);
    mem_if.mem_ready_in = 1; mem_if.mem_rdata_in = 32'h0F0F_0F0F;
    step();
    mem_if.mem_ready_in = 0;
    chk("wait data", reg_write_data_out, 32'h0F0F_0F0F);
`endif
    step();
    valid_in = 1; mem_ctl_in = 5'b01001; alu_result_in = 32'h101; reg_write_dest_in = 5'd10;
    step();
    valid_in = 0;
    chk("misalign req", 32'(mem_if.mem_req_out), 0);
    chk("misalign stall", 32'(stall_out), 0);
    chk("misalign err", 32'(mem_error_out), 1);
    chk("misalign wen", 32'(reg_write_en_out), 0);
    step();
    chk("misalign err sticky", 32'(mem_error_out), 1);
    valid_in = 1; mem_ctl_in = 5'b00001; alu_result_in = 32'h300; reg_write_dest_in = 5'd11;
    step();
    valid_in = 0;
    chk("pre-rst req", 32'(mem_if.mem_req_out), 1);
    #2 reset = 1;
    #1;
    chk("mid-rst req", 32'(mem_if.mem_req_out), 0);
    chk("mid-rst stall", 32'(stall_out), 0);
    chk("mid-rst err", 32'(mem_error_out), 0);
    chk("mid-rst be", 32'(mem_if.mem_be_out), 0);
    @(negedge clk); reset = 0;
    mem_if.mem_ready_in = 1;
    step();
    mem_if.mem_ready_in = 0;
    chk("post-rst no commit", 32'(reg_write_en_out), 0);
    valid_in = 1; mem_ctl_in = '0; reg_write_en_in = 1; reg_write_dest_in = 5'd12; alu_result_in = 32'h0000_BEEF; pc_seq_in = 32'h500;
    step();
    valid_in = 0;
    chk("post-rst wen", 32'(reg_write_en_out), 1);
    chk("post-rst data", reg_write_data_out, 32'h0000_BEEF);
    mem_op("post-rst lw", 5'b01001, 32'h40, 0, 5'd13, 32'h1357_9BDF, 1, 4'b1111, 0, 1, 32'h1357_9BDF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
